// File: rtl/vector_store_serializer.sv
// vector_store_serializer: buffers 8-lane vector stores from the core's memory
// stage in a DEPTH-entry FIFO and replays each lane as an 8-bit pixel write.
// Optional build macro VSS_SATURATE_EN: clamp each lane (two's complement) to
// 0..255 instead of plain truncation to the low byte.
module vector_store_serializer #(
  parameter int unsigned N      = 20,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         MemWriteM,
  input  logic [7:0][N-1:0]            ALUResultM,
  input  logic [7:0][N-1:0]            writeData,
  output logic                         StallOut,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [ADDR_W-1:0]            pix_addr,
  output logic [7:0]                   pix_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  // FIFO storage and control
  logic [ADDR_W-1:0]    mem_base_q [DEPTH];
  logic [7:0][N-1:0]    mem_data_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Serializer state
  state_e               state_q;
  logic [2:0]           lane_q;
  logic [2:0]           lane_nx;
  logic [ADDR_W-1:0]    ser_base_q;
  logic [7:0][N-1:0]    ser_data_q;
  logic                 pix_valid_q;
  logic [ADDR_W-1:0]    pix_addr_q;
  logic [7:0]           pix_data_q;

  logic                 push;
  logic                 pop;
  logic                 fifo_nonempty;
  logic [ADDR_W-1:0]    head_base;
  logic [7:0][N-1:0]    head_data;

  // Only lane 0's low address bits carry the store address.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{ALUResultM[7:1], ALUResultM[0][N-1:ADDR_W]};

  function automatic logic [7:0] lane_map(input logic [N-1:0] v);
`ifdef VSS_SATURATE_EN
    if (v[N-1])
      lane_map = '0;
    else if (|v[N-2:8])
      lane_map = '1;
    else
      lane_map = v[7:0];
`else
    lane_map = v[7:0];
`endif
  endfunction

  assign fifo_nonempty = (count_q != '0);
  assign StallOut      = (count_q == CNT_W'(DEPTH));
  assign push          = MemWriteM && !StallOut;
  // A pop happens when idle with data waiting, or when the last lane of the
  // in-flight entry hands off and another entry is waiting (no bubble).
  assign pop           = fifo_nonempty &&
                         ((state_q == IDLE) ||
                          (state_q == SEND && pix_ready && lane_q == 3'd7));
  assign head_base     = mem_base_q[rd_ptr_q];
  assign head_data     = mem_data_q[rd_ptr_q];
  assign lane_nx       = lane_q + 3'd1;

  // Next-state for FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer/occupancy registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate reads
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_base_q[wr_ptr_q] <= ALUResultM[0][ADDR_W-1:0];
      mem_data_q[wr_ptr_q] <= writeData;
    end
  end

  // Serializer FSM with registered pixel outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      ser_base_q  <= '0;
      ser_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_addr_q  <= '0;
      pix_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            ser_base_q  <= head_base;
            ser_data_q  <= head_data;
            lane_q      <= '0;
            pix_valid_q <= 1'b1;
            pix_addr_q  <= head_base;
            pix_data_q  <= lane_map(head_data[0]);
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (pix_ready) begin
            if (lane_q != 3'd7) begin
              lane_q     <= lane_nx;
              pix_addr_q <= pix_addr_q + 1'b1;
              pix_data_q <= lane_map(ser_data_q[lane_nx]);
            end else if (pop) begin
              ser_base_q <= head_base;
              ser_data_q <= head_data;
              lane_q     <= '0;
              pix_addr_q <= head_base;
              pix_data_q <= lane_map(head_data[0]);
            end else begin
              pix_valid_q <= 1'b0;
              lane_q      <= '0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count     = count_q;
  assign busy      = fifo_nonempty || (state_q == SEND);
  assign pix_valid = pix_valid_q;
  assign pix_addr  = pix_addr_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_vector_store_serializer.sv
// Testbench for vector_store_serializer: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_vector_store_serializer;

  localparam int unsigned N      = 20;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 16;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 MemWriteM;
  logic [7:0][N-1:0]    ALUResultM;
  logic [7:0][N-1:0]    writeData;
  logic                 StallOut;
  logic [2:0]           count;
  logic                 busy;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [ADDR_W-1:0]    pix_addr;
  logic [7:0]           pix_data;

  vector_store_serializer #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .writeData(writeData), .StallOut(StallOut), .count(count), .busy(busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
    .pix_data(pix_data)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted stores plus the entry being sent
  typedef struct {
    logic [15:0]       base;
    logic [7:0][19:0]  lanes;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  int   lane     = 0;
  bit   m_valid  = 0;
  bit   last_acc = 0;

  function automatic logic [7:0] exp_pix(input logic [19:0] raw);
    int v;
    v = int'($signed(raw));
`ifdef VSS_SATURATE_EN
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
`else
    return 8'(v & 255);
`endif
  endfunction

  task automatic model_edge();
    ent_t e;
    bit   acc;
    if (RST) begin
      q.delete();
      m_valid  = 0;
      lane     = 0;
      last_acc = 0;
      return;
    end
    acc = MemWriteM && (q.size() < DEPTH);
    if (!m_valid) begin
      if (q.size() > 0) begin
        cur = q.pop_front(); lane = 0; m_valid = 1;
      end
    end else if (pix_ready) begin
      if (lane < 7) lane++;
      else if (q.size() > 0) begin
        cur = q.pop_front(); lane = 0;
      end else m_valid = 0;
    end
    if (acc) begin
      e.base  = ALUResultM[0][15:0];
      e.lanes = writeData;
      q.push_back(e);
    end
    last_acc = acc;
  endtask

  task automatic compare();
    check("pix_valid", 32'(pix_valid), 32'(m_valid));
    if (m_valid) begin
      check("pix_addr", 32'(pix_addr), (int'(cur.base) + lane) % 65536);
      check("pix_data", 32'(pix_data), 32'(exp_pix(cur.lanes[lane])));
    end
    check("count", 32'(count), q.size());
    check("StallOut", 32'(StallOut), 32'(q.size() == DEPTH));
    check("busy", 32'(busy), 32'((q.size() != 0) || m_valid));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic set_store(input logic [15:0] base, input logic [7:0][19:0] lanes);
    MemWriteM  = 1'b1;
    for (int i = 0; i < 8; i++) ALUResultM[i] = 20'($urandom);
    ALUResultM[0] = {4'($urandom), base};
    writeData  = lanes;
  endtask

  task automatic push_store(input logic [15:0] base, input logic [7:0][19:0] lanes);
    int n;
    set_store(base, lanes);
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) check("push_timeout", 32'(StallOut), 32'd0);
    MemWriteM = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_valid || q.size() != 0) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [7:0][19:0] seq_lanes(input int start, input int stride);
    logic [7:0][19:0] l;
    for (int i = 0; i < 8; i++) l[i] = 20'(start + i * stride);
    return l;
  endfunction

  function automatic logic [7:0][19:0] rand_lanes();
    logic [7:0][19:0] l;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0: l[i] = 20'($urandom_range(0, 255));
        1: l[i] = 20'(-$urandom_range(1, 1000));
        default: l[i] = 20'($urandom);
      endcase
    end
    return l;
  endfunction

  logic [7:0][19:0] sat_l;
  logic [7:0]       sat_exp [3];
  int               beats;

  initial begin
    RST = 1'b1; MemWriteM = 1'b0; pix_ready = 1'b1;
    ALUResultM = '0; writeData = '0;
    repeat (3) step();
    check("rst_addr", 32'(pix_addr), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    RST = 1'b0;
    step();

    // Single store, latency and full stream
    push_store(16'h0100, seq_lanes(10, 10));
    check("lat_edge_t", 32'(pix_valid), 32'd0);
    step();
    check("lat_edge_t1", 32'(pix_valid), 32'd1);
    check("first_addr", 32'(pix_addr), 32'h0100);
    check("first_data", 32'(pix_data), 32'd10);
    drain();
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Backpressure during lane 3
    push_store(16'h2000, seq_lanes(1, 3));
    while (!(m_valid && lane == 3)) step();
    pix_ready = 1'b0;
    repeat (5) begin
      step();
      check("bp_addr", 32'(pix_addr), 32'h2003);
    end
    pix_ready = 1'b1;
    drain();

    // Full / stall: 6 back-to-back stores with the sink blocked
    pix_ready = 1'b0;
    for (int s = 0; s < 5; s++) push_store(16'(16'h3000 + s * 8), rand_lanes());
    check("full_count", 32'(count), 32'd4);
    check("full_stall", 32'(StallOut), 32'd1);
    set_store(16'h3100, rand_lanes());
    repeat (4) begin
      step();
      check("held_count", 32'(count), 32'd4);
    end
    pix_ready = 1'b1;
    beats = 0;
    while (!last_acc && beats < 50) begin
      step();
      beats++;
    end
    MemWriteM = 1'b0;
    check("sixth_accept", 32'(last_acc), 32'd1);
    drain();

    // Back-to-back entries: 16 consecutive beats
    push_store(16'h4000, seq_lanes(100, 1));
    push_store(16'h4008, seq_lanes(200, 1));
    while (!pix_valid && beats < 100) begin step(); beats++; end
    beats = 0;
    while (pix_valid && beats < 40) begin
      beats++;
      step();
    end
    check("b2b_beats", beats, 32'd16);

    // Address wrap
    push_store(16'hFFFC, rand_lanes());
    drain();

    // Lane mapping: -5, 300, 128
    sat_l = seq_lanes(0, 1);
    sat_l[0] = 20'(-5); sat_l[1] = 20'd300; sat_l[2] = 20'd128;
`ifdef VSS_SATURATE_EN
    sat_exp[0] = 8'd0;   sat_exp[1] = 8'd255;  sat_exp[2] = 8'd128;
`else
    sat_exp[0] = 8'hFB;  sat_exp[1] = 8'h2C;   sat_exp[2] = 8'h80;
`endif
    push_store(16'h5000, sat_l);
    step();
    for (int i = 0; i < 3; i++) begin
      check("map_lane", 32'(pix_data), 32'(sat_exp[i]));
      step();
    end
    drain();

    // Reset mid-burst: lane 4 in flight with 2 entries queued
    pix_ready = 1'b0;
    for (int s = 0; s < 3; s++) push_store(16'(16'h6000 + s * 16), rand_lanes());
    pix_ready = 1'b1;
    beats = 0;
    while (!(m_valid && lane == 4) && beats < 20) begin step(); beats++; end
    check("pre_rst_count", 32'(count), 32'd2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_stall", 32'(StallOut), 32'd0);
    repeat (12) step();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      if (!MemWriteM && $urandom_range(0, 2) == 0)
        set_store(16'($urandom), rand_lanes());
      step();
      if (last_acc) MemWriteM = 1'b0;
    end
    MemWriteM = 1'b0;
    pix_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_store_serializer.md
Name: vector_store_serializer

Overview:
- Downstream of the 8-lane vector filter core's memory stage.
- Captures vector stores (MemWriteM with address and 8 lanes of N-bit data), buffers them in a small FIFO, and serialises each lane into an 8-bit pixel write stream toward the output image RAM.
- Back-pressures the core through StallOut when the buffer is full.

Parameters:
- N, 20, lane width in bits; matches the core datapath.
- DEPTH, 4, FIFO depth in whole vector entries; power of 2, >= 2.
- ADDR_W, 16, pixel address width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- MemWriteM  input  1  store request from the core's memory stage.
- ALUResultM  input  [7:0][N-1:0]  store address; lane 0 bits [ADDR_W-1:0] are the base pixel address, lanes 1-7 are ignored.
- writeData  input  [7:0][N-1:0]  8 lane values to store.
- StallOut  output  1  FIFO full; the core must hold its store.
- count  output  $clog2(DEPTH+1)  FIFO occupancy in entries (serializer register excluded).
- busy  output  1  high when count != 0 or the serializer is active.
- pix_valid  output  1  pixel write valid.
- pix_ready  input  1  sink accepts the pixel.
- pix_addr  output  ADDR_W  pixel address.
- pix_data  output  8  pixel value.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, FIFO pointers=0, StallOut=0, busy=0, pix_valid=0, pix_addr=0, pix_data=0, lane index=0, state=IDLE.
  - Reset mid-operation discards all queued and in-flight data. No pixel handshake occurs on the reset edge.
- Push:
  - StallOut = (count==DEPTH), decoded from registered count.
  - A store is accepted at an edge iff MemWriteM && !StallOut. The entry is {ALUResultM[0][ADDR_W-1:0], writeData}.
  - A store presented while StallOut=1 is not captured; the core holds it.
- Serializer FSM:
  - IDLE: if count>0 at an edge, pop the head into the serializer register, set lane=0 and pix_valid=1, then go to SEND.
  - SEND:
    - pix_addr = base + lane, modulo 2^ADDR_W (wraps).
    - pix_data = lane value mapped per the Optional Feature.
    - While pix_valid && !pix_ready, all pix_* outputs are held stable.
    - On a handshake with lane<7: lane increments and the outputs update at that edge.
    - On a handshake with lane==7: if count>0, pop the next head and present its lane 0 at the same edge (no bubble). Otherwise clear pix_valid and go to IDLE.
- Simultaneous push and pop at the same edge: count is unchanged, and both pointers advance.
- Push into an empty FIFO while IDLE: the entry is accepted at edge t and popped at edge t+1. pix_valid is first high after edge t+1 (2-edge latency).
- Capacity is DEPTH entries queued plus 1 in flight.
- busy = (count!=0) || (state==SEND).

Optional Feature:
- Macro: VSS_SATURATE_EN.
- Defined: each lane is treated as N-bit two's complement and clamped. Negative values give 0; values >255 give 255; otherwise the low 8 bits.
- Undefined: pix_data = lane[7:0] (plain truncation).
- Everything else is identical in both builds.

Test Plan:
- Single store, pix_ready=1: one store with base=0x0100 and lanes 0..7 = 10,20,...,80. pix_valid rises 2 edges after the push; 8 consecutive beats at addr 0x0100..0x0107 with data 10..80; then IDLE and busy=0.
- Backpressure: pix_ready held low for 5 cycles during lane 3. pix_addr and pix_data stay at base+3 with unchanged data; resume on ready; no lane lost or repeated.
- Full/stall: pix_ready=0, 6 back-to-back stores. 5 are accepted (4 queued + 1 in flight); count=4 and StallOut=1 from the edge after the 5th push. The 6th is held, then accepted the edge after the first entry pops.
- Back-to-back: two queued stores with pix_ready=1. 16 consecutive beats with no pix_valid gap between lane 7 of entry 1 and lane 0 of entry 2.
- Address wrap: ADDR_W=16 with base=0xFFFC. Addresses are 0xFFFC..0xFFFF, then 0x0000..0x0003.
- Reset mid-burst and saturation:
  - Assert RST during lane 4 with 2 entries queued. The next cycle shows pix_valid=0, count=0, StallOut=0, and nothing is emitted afterward.
  - With VSS_SATURATE_EN, lanes -5, 300, 128 give 0, 255, 128.
  - Without VSS_SATURATE_EN, the same lanes give 0xFB, 0x2C, 0x80.
